// File: rtl/battery_soc_counter.sv
// battery_soc_counter: battery state-of-charge counter stepping one percent per paced interval
module battery_soc_counter #(
  parameter int FAST_TICKS   = 8,
  parameter int SLOW_TICKS   = 16,
  parameter int DISCH_TICKS  = 32,
  parameter int INIT_PERCENT = 20,
  parameter int LOW_THRESH   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       plug_in,
  input  logic       load_on,
  input  logic       charging_mode,
  output logic [6:0] battery_percent,
  output logic       charging,
  output logic       full,
  output logic       low_batt
);
  typedef enum logic [1:0] {IDLE = 2'b00, CHARGE = 2'b01, FULL = 2'b10, DISCH = 2'b11} state_t;
  localparam logic [15:0] FAST_L  = 16'(FAST_TICKS);
  localparam logic [15:0] SLOW_L  = 16'(SLOW_TICKS);
  localparam logic [15:0] DISCH_L = 16'(DISCH_TICKS);
  localparam logic [6:0]  INIT_P  = 7'(INIT_PERCENT);
  localparam logic [6:0]  LOW_T   = 7'(LOW_THRESH);
  state_t      state, state_nx;
  logic [15:0] tick_cnt, tick_nx, lim;
  logic [6:0]  lvl_nx;
  logic        step;
  assign charging = state == CHARGE;
  assign full     = state == FULL;
  // next state, pacing counter and level; tick_nx defaults to 0 so any state change clears it
  always_comb begin
    lim      = state == CHARGE ? (charging_mode ? SLOW_L : FAST_L) : DISCH_L;
    step     = tick_cnt >= lim - 16'd1;
    state_nx = state;
    tick_nx  = '0;
    lvl_nx   = battery_percent;
    case (state)
      IDLE:
        if (plug_in) state_nx = battery_percent == 7'd100 ? FULL : CHARGE;
        else if (load_on && battery_percent != 7'd0) state_nx = DISCH;
      CHARGE:
        if (!plug_in) state_nx = (load_on && battery_percent != 7'd0) ? DISCH : IDLE;
        else if (step) begin
          lvl_nx = battery_percent < 7'd100 ? battery_percent + 7'd1 : battery_percent;
          if (lvl_nx == 7'd100) state_nx = FULL;
        end else tick_nx = tick_cnt + 16'd1;
      FULL:
        if (!plug_in) state_nx = load_on ? DISCH : IDLE;
      DISCH:
        if (plug_in) state_nx = battery_percent == 7'd100 ? FULL : CHARGE;
        else if (!load_on) state_nx = IDLE;
        else if (step) begin
          lvl_nx = battery_percent > 7'd0 ? battery_percent - 7'd1 : battery_percent;
          if (lvl_nx == 7'd0) state_nx = IDLE;
        end else tick_nx = tick_cnt + 16'd1;
      default: state_nx = IDLE;
    endcase
  end
  // state, counter, level and low flag registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      tick_cnt        <= '0;
      battery_percent <= INIT_P;
      low_batt        <= INIT_P <= LOW_T;
    end else begin
      state           <= state_nx;
      tick_cnt        <= tick_nx;
      battery_percent <= lvl_nx;
      low_batt        <= lvl_nx <= LOW_T;
    end
  end
endmodule

// File: tb/tb_battery_soc_counter.sv
// tb_battery_soc_counter: directed scoreboard bench for battery_soc_counter
module tb_battery_soc_counter;
  logic       clk = 0, reset = 0, plug_in = 0, load_on = 0, charging_mode = 0;
  logic [6:0] battery_percent;
  logic       charging, full, low_batt;
  int checks = 0, failures = 0;
  typedef struct {
    string      name;
    logic [6:0] pct;
    logic       chg, fl, low;
  } exp_t;
  exp_t q[$];
  exp_t e;

  battery_soc_counter dut (
    .clk(clk), .reset(reset), .plug_in(plug_in), .load_on(load_on),
    .charging_mode(charging_mode), .battery_percent(battery_percent),
    .charging(charging), .full(full), .low_batt(low_batt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string name, input int pct, input logic chg, input logic fl, input logic low);
    q.push_back('{name, 7'(pct), chg, fl, low});
  endtask

  // monitor: compare every queued expectation on the falling edge
  always @(negedge clk)
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({battery_percent, charging, full, low_batt} !== {e.pct, e.chg, e.fl, e.low}) begin
        failures++;
        $display("FAIL %s: got pct=%0d chg=%b full=%b low=%b, want pct=%0d chg=%b full=%b low=%b",
                 e.name, battery_percent, charging, full, low_batt, e.pct, e.chg, e.fl, e.low);
      end
    end

  initial begin
    exp_out("reset", 20, 0, 0, 0);
    tick(2);
    reset = 1; plug_in = 1; charging_mode = 0;
    tick(1);  exp_out("charge_entry", 20, 1, 0, 0);
    tick(7);  exp_out("fast_pre_step", 20, 1, 0, 0);
    tick(1);  exp_out("fast_step1", 21, 1, 0, 0);
    tick(8);  exp_out("fast_step2", 22, 1, 0, 0);
    charging_mode = 1;
    tick(10); exp_out("slow_tick10", 22, 1, 0, 0);
    charging_mode = 0;
    tick(1);  exp_out("mode_switch_step", 23, 1, 0, 0);
    tick(7);  exp_out("fast_resume_pre", 23, 1, 0, 0);
    tick(1);  exp_out("fast_resume_step", 24, 1, 0, 0);
    tick(74 * 8); exp_out("at_98", 98, 1, 0, 0);
    tick(8);  exp_out("at_99", 99, 1, 0, 0);
    tick(7);  exp_out("pre_full", 99, 1, 0, 0);
    tick(1);  exp_out("full_entry", 100, 0, 1, 0);
    tick(200); exp_out("full_hold", 100, 0, 1, 0);
    plug_in = 0; load_on = 1;
    tick(1);  exp_out("disch_entry", 100, 0, 0, 0);
    tick(31); exp_out("disch_pre_step", 100, 0, 0, 0);
    tick(1);  exp_out("disch_step1", 99, 0, 0, 0);
    plug_in = 1;
    tick(1);  exp_out("plug_priority", 99, 1, 0, 0);
    tick(7);  exp_out("no_decrement", 99, 1, 0, 0);
    tick(1);  exp_out("refull", 100, 0, 1, 0);
    plug_in = 0;
    tick(1);  exp_out("disch_reentry", 100, 0, 0, 0);
    tick(84 * 32); exp_out("at_16", 16, 0, 0, 0);
    tick(32); exp_out("low_at_15", 15, 0, 0, 1);
    tick(13 * 32); exp_out("at_2", 2, 0, 0, 1);
    tick(32); exp_out("at_1", 1, 0, 0, 1);
    tick(31); exp_out("pre_empty", 1, 0, 0, 1);
    tick(1);  exp_out("empty", 0, 0, 0, 1);
    tick(100); exp_out("empty_hold", 0, 0, 0, 1);
    load_on = 0; plug_in = 1;
    tick(1);  exp_out("charge_from_0", 0, 1, 0, 1);
    tick(57 * 8); exp_out("at_57", 57, 1, 0, 0);
    tick(3);  exp_out("mid_count_57", 57, 1, 0, 0);
    @(posedge clk);
    #2 reset = 0;
    exp_out("async_reset", 20, 0, 0, 0);
    tick(3);  exp_out("reset_held", 20, 0, 0, 0);
    reset = 1;
    tick(1);  exp_out("post_reset_charge", 20, 1, 0, 0);
    tick(2);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
